// File: rtl/wb_burst_pkg.sv
// Shared types for the Wishbone burst initiator: FSM state
// encoding and the cyc/stb/we bus triples.
package wb_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // {cyc, stb, we}
  localparam logic [2:0] BUS_IDLE = 3'b000;
  localparam logic [2:0] BUS_RD   = 3'b110;
  localparam logic [2:0] BUS_WR   = 3'b111;

endpackage

// File: rtl/wb_beat_counter.sv
// Issued/acknowledged beat counter pair with length compares.
// Ports: clk, rst, clr, inc_iss, inc_ack, len in; more, last,
// ack_pend, ack_done out.
module wb_beat_counter #(
  parameter int LBITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_iss,
  input  logic             inc_ack,
  input  logic [LBITS-1:0] len,
  output logic             more,
  output logic             last,
  output logic             ack_pend,
  output logic             ack_done
);

  logic [LBITS-1:0] n_iss;
  logic [LBITS-1:0] n_ack;
  logic [LBITS-1:0] left;
  logic [LBITS-1:0] ack_nxt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      n_iss <= '0;
      n_ack <= '0;
    end else begin
      if (inc_iss) n_iss <= n_iss + LBITS'(1);
      if (inc_ack) n_ack <= n_ack + LBITS'(1);
    end
  end

  assign left     = len - n_iss;
  assign more     = n_iss < len;
  assign last     = left == LBITS'(1);
  assign ack_pend = n_ack < len;
  // inc_ack only fires while pending, so no wrap here
  assign ack_nxt  = n_ack + LBITS'(inc_ack);
  assign ack_done = ack_nxt == len;

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst initiator: one read/write burst command at a
// time; write beats from a valid/ready stream, read beats out on
// a valid-only stream. Ports: cmd_* command handshake, wr_* write
// stream, rd_* read stream, cyc/stb/we/bst/adr/dat/ack bus side,
// busy/done/err status. Optional ack watchdog: WB_MASTER_TIMEOUT_EN.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ABITS = 12,
  parameter int LBITS = 5,
  parameter int TBITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_req_i,
  input  logic             cmd_we_i,
  input  logic [ABITS-1:0] cmd_adr_i,
  input  logic [LBITS-1:0] cmd_len_i,
  output logic             cmd_ack_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  input  logic             ack_i,
  output logic [ABITS-1:0] adr_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic [WIDTH-1:0] dat_i,
  output logic             err_o
);

  state_t           state, state_d;
  logic             we_r, we_r_d;
  logic [LBITS-1:0] len_r, len_r_d;
  logic [ABITS-1:0] nxt_adr, nxt_adr_d;

  logic             cmd_ack_d, busy_d, done_d, err_d;
  logic             cyc_d, stb_d, we_d, bst_d;
  logic [ABITS-1:0] adr_d;
  logic [WIDTH-1:0] dat_d;
  logic             rd_valid_d;
  logic [WIDTH-1:0] rd_dat_d;

  logic clr, beat, ack_hit, abort;
  logic more, last, ack_pend, ack_done;

  wb_beat_counter #(.LBITS(LBITS)) u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (clr),
    .inc_iss  (beat),
    .inc_ack  (ack_hit),
    .len      (len_r),
    .more     (more),
    .last     (last),
    .ack_pend (ack_pend),
    .ack_done (ack_done)
  );

  // Acks beyond the burst length are not counted
  assign ack_hit = cyc_o & ack_i & ack_pend;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [TBITS-1:0] wdog;

  always_ff @(posedge clk_i) begin
    if (rst_i || !cyc_o || ack_i) begin
      wdog <= '0;
    end else if (ack_pend) begin
      wdog <= wdog + TBITS'(1);
    end
  end

  assign abort = cyc_o & (wdog == '1);
`else
  assign abort = 1'b0;
`endif

  assign wr_ready_o = (state == ISSUE) & we_r & more & ~abort;

  always_comb begin
    state_d    = state;
    we_r_d     = we_r;
    len_r_d    = len_r;
    nxt_adr_d  = nxt_adr;
    cmd_ack_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_o;
    cyc_d      = cyc_o;
    stb_d      = 1'b0;
    we_d       = we_o;
    bst_d      = 1'b0;
    adr_d      = adr_o;
    dat_d      = dat_o;
    rd_valid_d = ack_hit & ~we_r;
    rd_dat_d   = rd_dat_o;
    clr        = 1'b0;
    beat       = 1'b0;

    if (ack_hit && !we_r) rd_dat_d = dat_i;

    unique case (state)
      IDLE: begin
        if (cmd_req_i) begin
          cmd_ack_d = 1'b1;
          if (cmd_len_i != '0) begin
            clr       = 1'b1;
            state_d   = ISSUE;
            we_r_d    = cmd_we_i;
            len_r_d   = cmd_len_i;
            nxt_adr_d = cmd_adr_i;
            adr_d     = cmd_adr_i;
            busy_d    = 1'b1;
            cyc_d     = 1'b1;
            we_d      = cmd_we_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        beat = we_r ? (wr_valid_i & wr_ready_o) : more;
        if (beat) begin
          {cyc_d, stb_d, we_d} = we_r ? BUS_WR : BUS_RD;
          bst_d     = ~last;
          adr_d     = nxt_adr;
          nxt_adr_d = nxt_adr + ABITS'(1);
          if (we_r) dat_d = wr_dat_i;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ack_done) begin
          state_d              = IDLE;
          {cyc_d, stb_d, we_d} = BUS_IDLE;
          busy_d               = 1'b0;
          done_d               = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d              = IDLE;
      {cyc_d, stb_d, we_d} = BUS_IDLE;
      bst_d                = 1'b0;
      busy_d               = 1'b0;
      done_d               = 1'b1;
      err_d                = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      we_r       <= 1'b0;
      len_r      <= '0;
      nxt_adr    <= '0;
      cmd_ack_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      bst_o      <= 1'b0;
      adr_o      <= '0;
      dat_o      <= '0;
      rd_valid_o <= 1'b0;
      rd_dat_o   <= '0;
    end else begin
      state      <= state_d;
      we_r       <= we_r_d;
      len_r      <= len_r_d;
      nxt_adr    <= nxt_adr_d;
      cmd_ack_o  <= cmd_ack_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      err_o      <= err_d;
      cyc_o      <= cyc_d;
      stb_o      <= stb_d;
      we_o       <= we_d;
      bst_o      <= bst_d;
      adr_o      <= adr_d;
      dat_o      <= dat_d;
      rd_valid_o <= rd_valid_d;
      rd_dat_o   <= rd_dat_d;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed and random bursts against a
// 1-cycle-ack SRAM responder and a reference memory image.
module tb_wb_burst_master;

  localparam int WIDTH = 8;
  localparam int ABITS = 12;
  localparam int LBITS = 5;
  localparam int DEPTH = 1 << ABITS;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             cmd_req_i = 1'b0;
  logic             cmd_we_i = 1'b0;
  logic [ABITS-1:0] cmd_adr_i = '0;
  logic [LBITS-1:0] cmd_len_i = '0;
  logic             cmd_ack_o, busy_o, done_o;
  logic             wr_valid_i = 1'b0;
  logic             wr_ready_o;
  logic [WIDTH-1:0] wr_dat_i = '0;
  logic             rd_valid_o;
  logic [WIDTH-1:0] rd_dat_o;
  logic             cyc_o, stb_o, we_o, bst_o;
  logic             ack_i = 1'b0;
  logic [ABITS-1:0] adr_o;
  logic [WIDTH-1:0] dat_o;
  logic [WIDTH-1:0] dat_i = '0;
  logic             err_o;

  wb_burst_master #(
    .WIDTH(WIDTH), .ABITS(ABITS), .LBITS(LBITS), .TBITS(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cmd_req_i  (cmd_req_i),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_len_i  (cmd_len_i),
    .cmd_ack_o  (cmd_ack_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_dat_i   (wr_dat_i),
    .rd_valid_o (rd_valid_o),
    .rd_dat_o   (rd_dat_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .bst_o      (bst_o),
    .ack_i      (ack_i),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             we;
    logic [ABITS-1:0] adr;
    logic [WIDTH-1:0] dat;
    logic             bst;
    int               cyc;
  } beat_t;

  beat_t            beats[$];
  logic [WIDTH-1:0] rd_q[$];
  logic [WIDTH-1:0] wq[$];
  logic [WIDTH-1:0] mem[DEPTH];
  logic [WIDTH-1:0] ref_mem[DEPTH];

  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int err_n = 0;
  logic             ack_en = 1'b1;
  logic             prev_stb = 1'b0;
  logic             prev_we = 1'b0;
  logic [ABITS-1:0] prev_adr = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, record bus activity, drive the responder
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_no++;
    if (cyc_o && stb_o) begin
      beats.push_back('{we_o, adr_o, dat_o, bst_o, cyc_no});
      if (we_o) mem[adr_o] = dat_o;
    end
    if (rd_valid_o) rd_q.push_back(rd_dat_o);
    if (done_o) done_cyc = cyc_no;
    if (err_o) begin
      err_n++;
      err_cyc = cyc_no;
    end
    ack_i = ack_en && prev_stb;
    dat_i = (prev_stb && !prev_we) ? mem[prev_adr] : '0;
    prev_stb = cyc_o && stb_o;
    prev_we  = we_o;
    prev_adr = adr_o;
  endtask

  // mode: 0 continuous wr_valid, 1 every other cycle, 2 random
  task automatic run_cmd(input logic we, input logic [ABITS-1:0] adr,
                         input int len, input int mode);
    int idx, n, holes, acc, lim;
    bit seen, v;
    logic [ABITS-1:0] a;
    idx = 0; n = 0; holes = 0; seen = 0;
    while (wq.size() < len) wq.push_back(WIDTH'($urandom));
    beats.delete();
    rd_q.delete();
    cmd_we_i  = we;
    cmd_adr_i = adr;
    cmd_len_i = LBITS'(len);
    cmd_req_i = 1'b1;
    tick();
    chk("cmd_ack", cmd_ack_o, 1);
    chk("busy_cyc", {busy_o, cyc_o, we_o}, {2'b11, we});
    cmd_req_i = 1'b0;
    acc = cyc_no;
    while (!seen && n < 400) begin
      v = 0;
      if (we && idx < len) begin
        if (mode == 0) v = 1;
        else if (mode == 1) v = (n % 2 == 0);
        else v = 1'($urandom_range(0, 1));
      end
      wr_valid_i = v;
      wr_dat_i   = v ? wq[idx] : '0;
      if (v && wr_ready_o) idx++;
      tick();
      n++;
      if (done_o) seen = 1;
      else if (!cyc_o) holes++;
    end
    wr_valid_i = 1'b0;
    chk("done_seen", 32'(seen), 1);
    chk("cyc_held", holes, 0);
    chk("release", {cyc_o, busy_o, we_o}, 0);
    chk("beat_count", beats.size(), len);
    lim = beats.size() < len ? beats.size() : len;
    for (int k = 0; k < lim; k++) begin
      a = ABITS'(int'(adr) + k);
      chk("beat_adr", beats[k].adr, a);
      chk("beat_bst", 32'(beats[k].bst), 32'(k < len - 1));
      chk("beat_we", 32'(beats[k].we), 32'(we));
      if (we) chk("beat_dat", beats[k].dat, wq[k]);
      if (mode == 1 && k > 0)
        chk("beat_gap", beats[k].cyc - beats[k-1].cyc, 2);
    end
    if (lim > 0) begin
      chk("done_lat", done_cyc - beats[lim-1].cyc, 2);
      if (mode == 0) chk("first_lat", beats[0].cyc - acc, 1);
    end
    if (we) begin
      for (int k = 0; k < len; k++)
        ref_mem[ABITS'(int'(adr) + k)] = wq[k];
    end else begin
      chk("rd_count", rd_q.size(), len);
      lim = rd_q.size() < len ? rd_q.size() : len;
      for (int k = 0; k < lim; k++)
        chk("rd_dat", rd_q[k], ref_mem[ABITS'(int'(adr) + k)]);
    end
    wq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    bit w;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = WIDTH'($urandom);
      ref_mem[i] = mem[i];
    end

    rst_i = 1'b1;
    tick();
    tick();
    chk("rst_ctl", {cmd_ack_o, busy_o, done_o, rd_valid_o, err_o}, 0);
    chk("rst_bus", {cyc_o, stb_o, we_o, bst_o, wr_ready_o}, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_dat", {dat_o, rd_dat_o}, 0);
    rst_i = 1'b0;
    tick();

    // single write
    wq.push_back(8'hA5);
    run_cmd(1'b1, 12'h123, 1, 0);
    tick();

    // 16-beat write across the address wrap
    run_cmd(1'b1, 12'hFF8, 16, 0);
    chk("wrap_adr", beats[8].adr, 0);
    tick();

    // read it back
    run_cmd(1'b0, 12'hFF8, 8, 0);
    tick();

    // write with wr_valid gaps
    run_cmd(1'b1, 12'h200, 4, 1);
    tick();

    // zero-length command
    cmd_we_i  = 1'b1;
    cmd_len_i = '0;
    cmd_req_i = 1'b1;
    tick();
    chk("z_ack", cmd_ack_o, 1);
    chk("z_done", done_o, 1);
    chk("z_bus", {cyc_o, busy_o}, 0);
    cmd_req_i = 1'b0;
    tick();
    chk("z_after", {cyc_o, cmd_ack_o, done_o}, 0);

    // reset during beat 3 of a read
    beats.delete();
    cmd_we_i  = 1'b0;
    cmd_adr_i = 12'h040;
    cmd_len_i = 5'd8;
    cmd_req_i = 1'b1;
    tick();
    cmd_req_i = 1'b0;
    n = 0;
    while (beats.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_beat3", beats.size(), 3);
    rst_i = 1'b1;
    tick();
    chk("mid_cyc", {cyc_o, stb_o, busy_o}, 0);
    chk("mid_done", done_o, 0);
    rst_i = 1'b0;
    tick();
    chk("mid_after", {cyc_o, done_o}, 0);
    tick();

    // random bursts
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom_range(0, 1));
      run_cmd(w, ABITS'($urandom), $urandom_range(1, 31), w ? 2 : 0);
      tick();
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // stuck ack: watchdog abort
    ack_en = 1'b0;
    beats.delete();
    err_n = 0;
    cmd_we_i  = 1'b0;
    cmd_adr_i = 12'h010;
    cmd_len_i = 5'd1;
    cmd_req_i = 1'b1;
    tick();
    cmd_req_i = 1'b0;
    n = 0;
    while (err_n == 0 && n < 40) begin
      tick();
      n++;
    end
    chk("to_err", 32'(err_n), 1);
    chk("to_done", done_o, 1);
    if (beats.size() > 0)
      chk("to_lat", err_cyc - beats[$].cyc, 15);
    tick();
    chk("to_cyc", {cyc_o, err_o}, 0);
    ack_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
